// File: rtl/xmit_arbiter_if.sv
// Byte-source / transmitter bundle shared by the three responders and the arbiter.
// master: the source/transmitter side; slave: the arbiter itself.
interface xmit_arbiter_if;
  logic [2:0] req;
  logic [2:0] wr;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] data2;
  logic       xmit_idle;
  logic [2:0] grant;
  logic [2:0] src_idle;
  logic       xmit_write;
  logic [7:0] xmit_data;
  logic       busy;
  logic       err;

  modport master (
    output req, wr, data0, data1, data2, xmit_idle,
    input  grant, src_idle, xmit_write, xmit_data, busy, err
  );

  modport slave (
    input  req, wr, data0, data1, data2, xmit_idle,
    output grant, src_idle, xmit_write, xmit_data, busy, err
  );
endinterface

// File: rtl/xmit_arbiter.sv
// Round-robin arbiter sharing the SPI transmitter byte port between three sources.
// A grant is held for a whole transfer; accepted bytes are registered toward the
// transmitter and each source sees a gated idle so it paces itself as on the raw port.
module xmit_arbiter #(
  parameter int unsigned GUARD = 2  // idle-suppress cycles after a byte, 1..3
) (
  input logic          clock,
  input logic          extReset_n,
  xmit_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StGrant, StDrain} state_e;

  localparam logic [1:0] GuardInit = 2'(GUARD);

  state_e     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gcnt_q, gcnt_d;
  logic       xmit_write_q, xmit_write_d;
  logic [7:0] xmit_data_q, xmit_data_d;
  logic       err_q, err_d;

  logic [1:0] win;
  logic [1:0] ptr_n1, ptr_n2;
  logic [7:0] owner_data;
  logic       owner_wr, owner_req, foreign_wr, multi_wr, accept;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Round-robin winner: first requester scanning ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    ptr_n1 = inc3(ptr_q);
    ptr_n2 = inc3(ptr_n1);
    win    = ptr_n2;
    if (bus.req[ptr_q]) begin
      win = ptr_q;
    end else if (bus.req[ptr_n1]) begin
      win = ptr_n1;
    end
  end

  // Byte qualification: grant_q is zero outside GRANT, so every write there is foreign.
  always_comb begin
    unique case (owner_q)
      2'd0:    owner_data = bus.data0;
      2'd1:    owner_data = bus.data1;
      default: owner_data = bus.data2;
    endcase
    owner_wr   = |(bus.wr & grant_q);
    owner_req  = |(bus.req & grant_q);
    foreign_wr = |(bus.wr & ~grant_q);
    multi_wr   = (bus.wr & (bus.wr - 3'd1)) != 3'd0;
    accept     = (state_q == StGrant) && owner_wr && (gcnt_q == 2'd0);
  end

  // Next-state, guard counter, transmitter register and sticky error.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    gcnt_d       = (gcnt_q != 2'd0) ? gcnt_q - 2'd1 : 2'd0;
    xmit_write_d = accept;
    xmit_data_d  = accept ? owner_data : xmit_data_q;
    err_d        = err_q | foreign_wr | multi_wr | (owner_wr && gcnt_q != 2'd0);

    if (accept) begin
      gcnt_d = GuardInit;
    end

    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          grant_d = 3'b001 << win;
          owner_d = win;
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (!owner_req) begin
          grant_d = 3'b000;
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Wait for the last byte's guard and the transmitter before re-arbitrating.
        if (gcnt_q == 2'd0 && bus.xmit_idle) begin
          ptr_d   = inc3(owner_q);
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = 3'b000;
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset kills any in-flight write immediately.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      state_q      <= StIdle;
      grant_q      <= 3'b000;
      owner_q      <= 2'd0;
      ptr_q        <= 2'd0;
      gcnt_q       <= 2'd0;
      xmit_write_q <= 1'b0;
      xmit_data_q  <= 8'h00;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      gcnt_q       <= gcnt_d;
      xmit_write_q <= xmit_write_d;
      xmit_data_q  <= xmit_data_d;
      err_q        <= err_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.src_idle   = (state_q == StGrant && bus.xmit_idle && gcnt_q == 2'd0) ?
                          grant_q : 3'b000;
  assign bus.xmit_write = xmit_write_q;
  assign bus.xmit_data  = xmit_data_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.err        = err_q;

endmodule
